// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: issues cmd_steps registered step pulses, one per
// honoured rate tick, after a dir setup interval; supports early abort.
module step_pulse_gen #(
  parameter int STEP_BITS    = 16,
  parameter int PULSE_CYCLES = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [STEP_BITS-1:0] cmd_steps,
  input  logic                 cmd_dir,
  input  logic                 abort,
  output logic                 step,
  output logic                 dir,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [STEP_BITS-1:0] steps_left
);

  localparam int PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [PCW-1:0]       PULSE_LAST = PCW'(PULSE_CYCLES - 1);
  localparam logic [SCW-1:0]       SETUP_LAST = SCW'(SETUP_CYCLES - 1);
  localparam logic [STEP_BITS-1:0] STEP_ONE   = STEP_BITS'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_TICK,
    PULSE,
    DONE
  } state_t;

  state_t         state;
  logic [SCW-1:0] setup_cnt;
  logic [PCW-1:0] pulse_cnt;
  logic           abort_pend;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step       <= 1'b0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      steps_left <= '0;
      cmd_ready  <= 1'b1;
      setup_cnt  <= '0;
      pulse_cnt  <= '0;
      abort_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir        <= cmd_dir;
            steps_left <= cmd_steps;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            setup_cnt  <= '0;
            cmd_ready  <= 1'b0;
            if (cmd_steps != '0) begin
              state <= SETUP;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SETUP: begin
          if (abort) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (setup_cnt == SETUP_LAST) begin
            state <= WAIT_TICK;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end

        WAIT_TICK: begin
          // abort takes priority over a tick sampled on the same edge
          if (abort) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (tick) begin
            state     <= PULSE;
            step      <= 1'b1;
            pulse_cnt <= '0;
            if (steps_left != '0) begin
              steps_left <= steps_left - STEP_ONE;
            end
          end
        end

        PULSE: begin
          if (abort) begin
            abort_pend <= 1'b1;
          end
          if (pulse_cnt == PULSE_LAST) begin
            step <= 1'b0;
            // an abort on the final pulse edge is honoured just like a latched one
            if (abort_pend || abort || steps_left == '0) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              aborted <= abort_pend | abort;
            end else begin
              state <= WAIT_TICK;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          step      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter STEP_BITS, default 16, width of the step count and the steps_left output.
REQ-002 Parameter PULSE_CYCLES, default 4, clk cycles the step output is held high per step (minimum 1).
REQ-003 Parameter SETUP_CYCLES, default 2, clk cycles between dir update and the first tick being honoured (minimum 1).
REQ-004 clk  in  1  clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 tick  in  1  rate pulse from the upstream frequency divider; one step is issued per honoured tick.
REQ-007 cmd_valid  in  1  command present.
REQ-008 cmd_ready  out  1  block can accept a command.
REQ-009 cmd_steps  in  STEP_BITS  number of steps to issue.
REQ-010 cmd_dir  in  1  direction for the command.
REQ-011 abort  in  1  request early termination of the active command.
REQ-012 step  out  1  motor step pulse.
REQ-013 dir  out  1  motor direction, registered.
REQ-014 busy  out  1  command in progress.
REQ-015 done  out  1  single-cycle completion strobe.
REQ-016 aborted  out  1  last command ended by abort; held until next accept.
REQ-017 steps_left  out  STEP_BITS  steps not yet issued for the current or last command.

Function
REQ-018 States SHALL be IDLE, SETUP, WAIT_TICK, PULSE, DONE; cmd_ready SHALL be 1 only in IDLE; busy SHALL be 1 in SETUP, WAIT_TICK, PULSE.
REQ-019 Accept occurs on an edge with cmd_valid && cmd_ready; at that edge dir <= cmd_dir, steps_left <= cmd_steps, aborted <= 0.
REQ-020 Accept with cmd_steps != 0 SHALL move to SETUP; cmd_steps == 0 SHALL move to DONE with no step pulse.
REQ-021 SETUP SHALL last exactly SETUP_CYCLES cycles, then move to WAIT_TICK; ticks during SETUP are ignored.
REQ-022 In WAIT_TICK, tick sampled high at an edge SHALL move to PULSE and decrement steps_left at that same edge.
REQ-023 In PULSE, step SHALL be 1 for exactly PULSE_CYCLES consecutive cycles, registered (no combinational path from tick to step).
REQ-024 Ticks arriving in PULSE SHALL be dropped, not queued.
REQ-025 At the end of PULSE: steps_left == 0 -> DONE, else -> WAIT_TICK.
REQ-026 DONE SHALL last one cycle with done = 1, then return to IDLE; step = 0 in DONE.
REQ-027 abort sampled high in SETUP or WAIT_TICK SHALL move to DONE at that edge with aborted <= 1; steps_left is not modified.
REQ-028 abort sampled high in PULSE SHALL be latched; the pulse completes its full PULSE_CYCLES, then DONE with aborted = 1 regardless of steps_left.
REQ-029 abort in IDLE or DONE SHALL have no effect; abort and accept on the same edge -> accept wins.
REQ-030 dir SHALL not change while busy or in DONE; cmd inputs are ignored outside IDLE.
REQ-031 steps_left decrement SHALL never wrap below 0.

Reset
REQ-032 reset SHALL force state IDLE, step 0, dir 0, busy 0, done 0, aborted 0, steps_left 0, cmd_ready 1 at the next edge, overriding all other inputs.
REQ-033 reset asserted mid-PULSE SHALL drop step at the next edge (truncated pulse permitted) with no done strobe.

Verification
REQ-034 PULSE_CYCLES=4, SETUP_CYCLES=2; accept cmd_steps=3, dir=1, tick every 10 cycles -> 3 step pulses each 4 cycles high, steps_left 2,1,0, done once, aborted 0.
REQ-035 Accept cmd_steps=0 -> done high exactly one cycle after accept, step never high, busy never high.
REQ-036 cmd_steps=5, tick held high continuously -> pulses separated by one WAIT_TICK cycle, ticks during PULSE dropped, exactly 5 pulses.
REQ-037 cmd_steps=10, abort during 3rd pulse -> 3rd pulse full width, done, aborted=1, steps_left=7; abort in WAIT_TICK after 2 steps -> steps_left=8.
REQ-038 reset asserted during 2nd pulse of cmd_steps=4 -> next edge step=0, busy=0, steps_left=0, cmd_ready=1, no done.
REQ-039 cmd_dir toggled and cmd_valid held while busy -> dir constant, no second accept until IDLE.
